// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the next-PC sequencer.
//   - seq_state_t : architectural sequencer state, encoding visible on the
//                   pc_sequencer.state output (RUN=0, FLUSH=1, HALT=2, TRAP=3)
//   - run_event_t : winning event of the RUN-state priority select
//   - default reset/trap vectors, sequential step and flush length
//   - is_misaligned() : word-alignment test for redirect targets
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2,
      ST_TRAP  = 2'd3
   } seq_state_t;

   typedef enum logic [2:0] {
      EV_TRAP     = 3'd0,
      EV_MISALIGN = 3'd1,
      EV_HALT     = 3'd2,
      EV_REDIRECT = 3'd3,
      EV_HOLD     = 3'd4,
      EV_STEP     = 3'd5
   } run_event_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0040;
   localparam int unsigned DEFAULT_PC_STEP      = 4;
   localparam int unsigned DEFAULT_FLUSH_CYCLES = 1;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational priority select used while the sequencer is in
// RUN. Picks the winning event (trap > misaligned redirect > halt > jump >
// branch > stall > increment) and the pc that event would load.
// Ports:
//   pc            in  32  current fetch address
//   stall         in   1  hazard hold
//   branch_taken  in   1  conditional branch taken
//   branch_target in  32  branch destination
//   jump          in   1  unconditional jump
//   jump_target   in  32  jump destination
//   trap_req      in   1  trap request
//   halt_req      in   1  halt request
//   ev_sel        out  3  winning event
//   next_pc       out 32  pc value associated with ev_sel
module pc_next_mux
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR,
   parameter int unsigned PC_STEP     = DEFAULT_PC_STEP
) (
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap_req,
   input  logic        halt_req,
   output run_event_t  ev_sel,
   output logic [31:0] next_pc
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic        redirect;
   logic [31:0] target;

   // Jump outranks branch, so only the jump target is ever alignment-checked
   // when both fire together.
   assign redirect = jump | branch_taken;
   assign target   = jump ? jump_target : branch_target;

   always_comb begin
      ev_sel  = EV_STEP;
      next_pc = pc + STEP;  // wraps modulo 2^32
      if (trap_req) begin
         ev_sel  = EV_TRAP;
         next_pc = TRAP_VECTOR;
      end else if (redirect && is_misaligned(target)) begin
         ev_sel  = EV_MISALIGN;
         next_pc = TRAP_VECTOR;
      end else if (halt_req) begin
         ev_sel  = EV_HALT;
         next_pc = pc;
      end else if (redirect) begin
         ev_sel  = EV_REDIRECT;
         next_pc = target;
      end else if (stall) begin
         ev_sel  = EV_HOLD;
         next_pc = pc;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and decides every cycle whether to
// increment, hold, redirect, trap or halt. All outputs are registered.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   stall                       freeze pc (RUN) or flush counter (FLUSH)
//   branch_taken/branch_target  conditional redirect
//   jump/jump_target            unconditional redirect
//   trap_req                    trap request (honoured in RUN, FLUSH, HALT)
//   halt_req / resume           enter / leave HALT
//   pc                          current fetch address
//   fetch_valid                 pc is a real fetch, not a bubble
//   flush                       one-cycle pulse per redirect or trap
//   epc                         pc saved on trap entry
//   misaligned                  last trap was caused by a misaligned target
//   state                       RUN=0, FLUSH=1, HALT=2, TRAP=3
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
   parameter int unsigned PC_STEP      = DEFAULT_PC_STEP,
   parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES  // legal 1..3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap_req,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        flush,
   output logic [31:0] epc,
   output logic        misaligned,
   output logic [1:0]  state
);

   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

   seq_state_t  state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] epc_reg, epc_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic        mis_reg, mis_next;
   logic        flush_reg, flush_next;
   logic        fv_reg, fv_next;

   run_event_t  ev_sel;
   logic [31:0] mux_pc;
   logic        take_trap;
   logic        trap_mis;

   pc_next_mux #(
      .TRAP_VECTOR (TRAP_VECTOR),
      .PC_STEP     (PC_STEP)
   ) u_mux (
      .pc            (pc_reg),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap_req      (trap_req),
      .halt_req      (halt_req),
      .ev_sel        (ev_sel),
      .next_pc       (mux_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_RUN;
         pc_reg    <= RESET_VECTOR;
         epc_reg   <= 32'h0;
         cnt_reg   <= 2'd0;
         mis_reg   <= 1'b0;
         flush_reg <= 1'b0;
         fv_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         epc_reg   <= epc_next;
         cnt_reg   <= cnt_next;
         mis_reg   <= mis_next;
         flush_reg <= flush_next;
         fv_reg    <= fv_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      epc_next   = epc_reg;
      cnt_next   = cnt_reg;
      mis_next   = mis_reg;
      flush_next = 1'b0;       // flush is a single-cycle pulse
      fv_next    = fv_reg;
      take_trap  = 1'b0;
      trap_mis   = 1'b0;

      case (state_reg)
         ST_RUN: begin
            case (ev_sel)
               EV_TRAP:     take_trap = 1'b1;
               EV_MISALIGN: begin
                  take_trap = 1'b1;
                  trap_mis  = 1'b1;
               end
               EV_HALT: begin
                  state_next = ST_HALT;
                  fv_next    = 1'b0;
               end
               EV_REDIRECT: begin
                  pc_next    = mux_pc;
                  flush_next = 1'b1;
                  state_next = ST_FLUSH;
                  cnt_next   = FLUSH_INIT;
                  fv_next    = 1'b0;
               end
               EV_HOLD: ;
               default: pc_next = mux_pc;
            endcase
         end
         ST_FLUSH: begin
            // Redirects are ignored while bubbling; only traps get through.
            if (trap_req) begin
               take_trap = 1'b1;
            end else if (!stall) begin
               if (cnt_reg <= 2'd1) begin
                  cnt_next   = 2'd0;
                  state_next = ST_RUN;
                  fv_next    = 1'b1;
               end else begin
                  cnt_next = cnt_reg - 2'd1;
               end
            end
         end
         ST_HALT: begin
            if (trap_req) begin
               take_trap = 1'b1;
            end else if (resume) begin
               state_next = ST_RUN;
               fv_next    = 1'b1;
            end
         end
         default: begin
            // TRAP lasts exactly one cycle; pc stays on the trap vector so
            // the handler's first instruction is fetched on return to RUN.
            state_next = ST_RUN;
            fv_next    = 1'b1;
         end
      endcase

      if (take_trap) begin
         epc_next   = pc_reg;
         pc_next    = TRAP_VECTOR;
         flush_next = 1'b1;
         state_next = ST_TRAP;
         fv_next    = 1'b0;
         mis_next   = trap_mis;
         cnt_next   = 2'd0;
      end
   end

   assign pc          = pc_reg;
   assign fetch_valid = fv_reg;
   assign flush       = flush_reg;
   assign epc         = epc_reg;
   assign misaligned  = mis_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] TV   = 32'h0000_0040;
   localparam int          FC   = 1;
   localparam int          NRND = 1500;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        trap_req;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        flush;
   logic [31:0] epc;
   logic        misaligned;
   logic [1:0]  state;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap_req      (trap_req),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc            (pc),
      .fetch_valid   (fetch_valid),
      .flush         (flush),
      .epc           (epc),
      .misaligned    (misaligned),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        fv;
      logic        fl;
      logic        mis;
      logic [1:0]  st;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: mode 0=RUN 1=FLUSH 2=HALT 3=TRAP, bubbles_left counts
   // remaining flush bubbles.
   logic [31:0] m_pc, m_epc;
   int          m_mode, m_left;
   bit          m_fv, m_fl, m_mis;

   function automatic void m_trap(bit cause_mis);
      m_epc  = m_pc;
      m_pc   = TV;
      m_fl   = 1;
      m_fv   = 0;
      m_mode = 3;
      m_mis  = cause_mis;
   endfunction

   function automatic void model(bit r, bit st, bit br, logic [31:0] bt, bit jp,
                                 logic [31:0] jt, bit tr, bit hl, bit rs);
      logic [31:0] tgt;
      tgt = jp ? jt : bt;
      if (r) begin
         m_pc = RV; m_epc = 0; m_mode = 0; m_left = 0;
         m_fv = 1; m_fl = 0; m_mis = 0;
         return;
      end
      m_fl = 0;
      if (m_mode == 0) begin
         if (tr) m_trap(0);
         else if ((jp || br) && (tgt % 4 != 0)) m_trap(1);
         else if (hl) begin m_mode = 2; m_fv = 0; end
         else if (jp || br) begin
            m_pc = tgt; m_mode = 1; m_left = FC; m_fv = 0; m_fl = 1;
         end
         else if (!st) m_pc = m_pc + 4;
      end else if (m_mode == 1) begin
         if (tr) m_trap(0);
         else if (!st) begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_mode = 0; m_fv = 1; end
         end
      end else if (m_mode == 2) begin
         if (tr) m_trap(0);
         else if (rs) begin m_mode = 0; m_fv = 1; end
      end else begin
         m_mode = 0; m_fv = 1;
      end
   endfunction

   task automatic step(bit r, bit st, bit br, logic [31:0] bt, bit jp,
                       logic [31:0] jt, bit tr, bit hl, bit rs);
      obs_t e;
      @(negedge clk);
      reset = r; stall = st; branch_taken = br; branch_target = bt;
      jump = jp; jump_target = jt; trap_req = tr; halt_req = hl; resume = rs;
      model(r, st, br, bt, jp, jt, tr, hl, rs);
      e.pc = m_pc; e.epc = m_epc; e.fv = m_fv; e.fl = m_fl; e.mis = m_mis;
      e.st = 2'(m_mode);
      exp_q.push_back(e);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_jump(logic [31:0] t);
      step(0, 0, 0, 0, 1, t, 0, 0, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic pin(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end else begin
         $display("check %s = %h", name, act);
      end
   endtask

   // Monitor: every cycle the DUT presents a registered result; pop and compare.
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pc = pc; a.epc = epc; a.fv = fetch_valid; a.fl = flush;
            a.mis = misaligned; a.st = state;
            total++;
            cyc++;
            if (a !== e) begin
               bad++;
               $display("FAIL cycle %0d: got pc=%h epc=%h fv=%b fl=%b mis=%b st=%0d want pc=%h epc=%h fv=%b fl=%b mis=%b st=%0d",
                        cyc, a.pc, a.epc, a.fv, a.fl, a.mis, a.st,
                        e.pc, e.epc, e.fv, e.fl, e.mis, e.st);
            end else begin
               $display("cyc %0d pc=%h st=%0d fv=%b fl=%b ok", cyc, a.pc, a.st, a.fv, a.fl);
            end
         end
      end
   end

   function automatic logic [31:0] rnd_target();
      logic [31:0] t;
      int          r;
      r = $urandom_range(0, 9);
      t = $urandom;
      if (r < 2) return t | 32'h1;
      if (r < 3) return 32'hFFFF_FFFC;
      t[1:0] = 2'b00;
      return t;
   endfunction

   initial begin
      reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
      jump = 0; jump_target = 0; trap_req = 0; halt_req = 0; resume = 0;

      // Reset and free-running increment
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 32'h55, 1, 32'h66, 1, 1, 1);
      settle();
      pin("reset_pc", pc, RV);
      pin("reset_fv", 32'(fetch_valid), 32'd1);
      pin("reset_state", 32'(state), 32'd0);
      idle(3);
      settle();
      pin("inc_pc12", pc, 32'd12);

      // Aligned jump from pc=8
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      do_jump(32'h100);
      settle();
      pin("jump_pc", pc, 32'h100);
      pin("jump_flush", 32'(flush), 32'd1);
      pin("jump_fv", 32'(fetch_valid), 32'd0);
      idle(1);
      settle();
      pin("post_flush_fv", 32'(fetch_valid), 32'd1);
      idle(1);
      settle();
      pin("post_flush_pc", pc, 32'h104);

      // Misaligned branch at pc=0x20
      do_jump(32'h20);
      idle(1);
      step(0, 0, 1, 32'h102, 0, 0, 0, 0, 0);
      settle();
      pin("mis_pc", pc, TV);
      pin("mis_epc", epc, 32'h20);
      pin("mis_flag", 32'(misaligned), 32'd1);
      pin("mis_state", 32'(state), 32'd3);
      idle(1);
      settle();
      pin("after_trap_state", 32'(state), 32'd0);

      // Stall for three cycles with a jump in the second
      do_jump(32'h10);
      idle(1);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      pin("stall_pc", pc, 32'h10);
      step(0, 1, 0, 0, 1, 32'h200, 0, 0, 0);
      settle();
      pin("stall_jump_pc", pc, 32'h200);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      pin("stall_in_flush", 32'(state), 32'd1);
      idle(1);

      // Halt at 0x30, resume, then trap+resume while halted
      do_jump(32'h30);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      settle();
      pin("halt_pc", pc, 32'h30);
      pin("halt_fv", 32'(fetch_valid), 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      pin("resume_pc", pc, 32'h30);
      idle(1);
      settle();
      pin("resume_inc", pc, 32'h34);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 1);
      settle();
      pin("halt_trap_state", 32'(state), 32'd3);
      pin("halt_trap_epc", epc, 32'h34);
      pin("halt_trap_mis", 32'(misaligned), 32'd0);
      idle(1);

      // Reset during FLUSH, then wrap-around
      do_jump(32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      pin("reset_in_flush_pc", pc, RV);
      pin("reset_in_flush_state", 32'(state), 32'd0);
      do_jump(32'hFFFF_FFFC);
      idle(2);
      settle();
      pin("wrap_pc", pc, 32'h0);

      // Randomized phase
      for (int i = 0; i < NRND; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 10, rnd_target(),
              $urandom_range(0, 99) < 8, rnd_target(),
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 30);
      end
      idle(1);
      settle();
      settle();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
